// File: rtl/huffman_stream_encoder.sv
// Serial Huffman encoder: run-time writable code table, valid/ready symbol
// input, MSB-first bit stream output with backpressure and zero-bubble
// symbol acceptance on the last bit of a codeword.
module huffman_stream_encoder #(
   parameter int SYM_W   = 5,
   parameter int MAX_LEN = 12,
   parameter int LEN_W   = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               tbl_we,
   input  logic [SYM_W-1:0]   tbl_addr,
   input  logic [MAX_LEN-1:0] tbl_code,
   input  logic [LEN_W-1:0]   tbl_len,
   input  logic               sym_valid,
   output logic               sym_ready,
   input  logic [SYM_W-1:0]   sym_data,
   output logic               bit_valid,
   input  logic               bit_ready,
   output logic               bit_out,
   output logic               bit_last,
   output logic               sym_err,
   output logic               busy
);

   localparam int DEPTH = 1 << SYM_W;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_nx;
   logic [MAX_LEN-1:0] code_tbl [DEPTH];
   logic [LEN_W-1:0]   len_tbl  [DEPTH];
   logic [MAX_LEN-1:0] shreg, shreg_nx;
   logic [LEN_W-1:0]   cnt, cnt_nx;
   logic               sym_err_nx;
   logic [MAX_LEN-1:0] lk_code;
   logic [LEN_W-1:0]   lk_len;
   logic               lk_ok;
   logic               xfer;
   logic               last_hs;
   logic [LEN_W-1:0]   bit_idx;
   logic [MAX_LEN-1:0] sh_view;

   // Code table storage; cleared on reset, written in any state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            code_tbl[i] <= '0;
            len_tbl[i]  <= '0;
         end
      end else if (tbl_we) begin
         code_tbl[tbl_addr] <= tbl_code;
         len_tbl[tbl_addr]  <= tbl_len;
      end
   end

   // Table lookup and output decode from the current state
   always_comb begin
      lk_code   = code_tbl[sym_data];
      lk_len    = len_tbl[sym_data];
      lk_ok     = (lk_len != '0) && (lk_len <= LEN_W'(MAX_LEN));
      bit_valid = (state == SHIFT);
      busy      = (state == SHIFT);
      bit_last  = (state == SHIFT) && (cnt == LEN_W'(1));
      // Select shreg[cnt-1] via a shift so the index never exceeds the vector
      bit_idx   = cnt - LEN_W'(1);
      sh_view   = shreg >> bit_idx;
      bit_out   = (state == SHIFT) && sh_view[0];
      last_hs   = bit_valid && bit_ready && bit_last;
      sym_ready = (state == IDLE) || last_hs;
      xfer      = sym_valid && sym_ready;
   end

   // Next-state: advance on bit handshake, then a symbol transfer overrides
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      cnt_nx     = cnt;
      sym_err_nx = 1'b0;
      if ((state == SHIFT) && bit_ready) begin
         if (cnt == LEN_W'(1)) state_nx = IDLE;
         else                  cnt_nx   = cnt - LEN_W'(1);
      end
      if (xfer) begin
         if (lk_ok) begin
            state_nx = SHIFT;
            shreg_nx = lk_code;
            cnt_nx   = lk_len;
         end else begin
            state_nx   = IDLE;
            sym_err_nx = 1'b1;
         end
      end
   end

   // State, shift register, counter and error pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         sym_err <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         cnt     <= cnt_nx;
         sym_err <= sym_err_nx;
      end
   end

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Self-checking bench: negedge monitor with an expected-bit scoreboard,
// table-driven single-symbol vectors, and hand sequences for stalls,
// back-to-back symbols, in-flight table rewrites and mid-codeword reset.
module tb_huffman_stream_encoder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        tbl_we;
   logic [4:0]  tbl_addr;
   logic [11:0] tbl_code;
   logic [3:0]  tbl_len;
   logic        sym_valid;
   logic        sym_ready;
   logic [4:0]  sym_data;
   logic        bit_valid;
   logic        bit_ready;
   logic        bit_out;
   logic        bit_last;
   logic        sym_err;
   logic        busy;

   huffman_stream_encoder #(.SYM_W(5), .MAX_LEN(12), .LEN_W(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
      .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
      .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
      .bit_last(bit_last), .sym_err(sym_err), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct { logic b; logic last; } exp_bit_t;
   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [11:0] code;
      logic [3:0]  len;
      logic        exp_err;
      int          exp_n;
      logic [31:0] exp_bits;
   } vec_t;

   exp_bit_t    q[$];
   logic [11:0] m_code [32];
   logic [3:0]  m_len  [32];
   logic        err_pend = 1'b0;
   logic        err_seen = 1'b0;
   logic        accepted = 1'b0;
   logic [31:0] coll = '0;
   int          coll_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT against the scoreboard, then update the model
   always @(negedge clock) begin
      logic exp_valid, exp_ready;
      if (!reset_n) begin
         chk("rst_bit_valid", bit_valid, 0);
         chk("rst_bit_out", bit_out, 0);
         chk("rst_bit_last", bit_last, 0);
         chk("rst_sym_err", sym_err, 0);
         chk("rst_busy", busy, 0);
         q.delete();
         err_pend = 1'b0;
         for (int i = 0; i < 32; i++) begin
            m_code[i] = '0;
            m_len[i]  = '0;
         end
      end else begin
         exp_valid = (q.size() != 0);
         exp_ready = !exp_valid || (bit_ready && q[0].last);
         chk("bit_valid", bit_valid, exp_valid);
         chk("busy", busy, exp_valid);
         chk("sym_ready", sym_ready, exp_ready);
         chk("sym_err", sym_err, err_pend);
         if (sym_err) err_seen = 1'b1;
         if (exp_valid) begin
            chk("bit_out", bit_out, q[0].b);
            chk("bit_last", bit_last, q[0].last);
            if (bit_ready) begin
               void'(q.pop_front());
               coll = {coll[30:0], bit_out};
               coll_n++;
            end
         end
         err_pend = 1'b0;
         if (sym_valid && exp_ready) begin
            logic [3:0]  l;
            logic [11:0] c;
            l = m_len[sym_data];
            c = m_code[sym_data];
            accepted = 1'b1;
            if (l != 0 && l <= 12) begin
               for (int i = int'(l) - 1; i >= 0; i--) q.push_back('{c[i], i == 0});
            end else begin
               err_pend = 1'b1;
            end
         end
         if (tbl_we) begin
            m_code[tbl_addr] = tbl_code;
            m_len[tbl_addr]  = tbl_len;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [11:0] c, input logic [3:0] l);
      tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic send(input logic [4:0] s);
      sym_valid = 1'b1;
      sym_data  = s;
      accepted  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (accepted) break;
      end
      chk("send_accept", accepted, 1);
      sym_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (q.size() == 0 && !err_pend) begin
            idle = 1'b1;
            break;
         end
         tick();
      end
      chk("wait_idle", idle, 1);
   endtask

   task automatic clr();
      coll = '0; coll_n = 0; err_seen = 1'b0;
   endtask

   task automatic expect_run(input string nm, input int n, input logic [31:0] bits, input logic err);
      chk({nm, "_nbits"}, coll_n, n);
      chk({nm, "_bits"}, coll, bits);
      chk({nm, "_err"}, err_seen, err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 5'd3,  12'h000, 4'd0,  1'b1, 0,  32'h0};
      vecs[1] = '{1'b1, 5'd5,  12'h005, 4'd3,  1'b0, 3,  32'h5};
      vecs[2] = '{1'b1, 5'd7,  12'hFFF, 4'd12, 1'b0, 12, 32'hFFF};
      vecs[3] = '{1'b1, 5'd8,  12'h005, 4'd13, 1'b1, 0,  32'h0};
      vecs[4] = '{1'b1, 5'd9,  12'h000, 4'd0,  1'b1, 0,  32'h0};
      vecs[5] = '{1'b1, 5'd31, 12'hA5C, 4'd12, 1'b0, 12, 32'hA5C};
      vecs[6] = '{1'b1, 5'd12, 12'hFF3, 4'd4,  1'b0, 4,  32'h3};

      reset_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
      sym_valid = 1'b0; sym_data = '0; bit_ready = 1'b1;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("post_reset_ready", sym_ready, 1);

      // Single-symbol vectors
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].wr) wr(vecs[v].addr, vecs[v].code, vecs[v].len);
         clr();
         send(vecs[v].addr);
         wait_idle();
         tick();
         expect_run($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_bits, vecs[v].exp_err);
      end

      // Backpressure: stall the second bit for two cycles
      clr();
      send(5'd5);
      tick();
      bit_ready = 1'b0;
      chk("stall_ready", sym_ready, 0);
      tick();
      chk("stall_hold_out", bit_out, 0);
      chk("stall_hold_valid", bit_valid, 1);
      tick();
      bit_ready = 1'b1;
      wait_idle();
      tick();
      expect_run("stall", 3, 32'h5, 1'b0);

      // Back-to-back 1,2,1 with no bubbles
      wr(5'd1, 12'h001, 4'd1);
      wr(5'd2, 12'h001, 4'd2);
      clr();
      send(5'd1);
      send(5'd2);
      send(5'd1);
      wait_idle();
      tick();
      expect_run("b2b", 4, 32'hB, 1'b0);

      // Rewrite entry 5 during the second bit of its codeword
      clr();
      send(5'd5);
      tick();
      wr(5'd5, 12'h003, 4'd2);
      wait_idle();
      tick();
      expect_run("inflight_old", 3, 32'h5, 1'b0);
      clr();
      send(5'd5);
      wait_idle();
      tick();
      expect_run("inflight_new", 2, 32'h3, 1'b0);

      // Write and lookup in the same cycle sees the old entry
      clr();
      tbl_we = 1'b1; tbl_addr = 5'd5; tbl_code = 12'h000; tbl_len = 4'd1;
      send(5'd5);
      tbl_we = 1'b0;
      wait_idle();
      tick();
      expect_run("same_cycle_wr", 2, 32'h3, 1'b0);

      // Reset mid-codeword aborts and clears the table
      clr();
      send(5'd7);
      tick(); tick();
      reset_n = 1'b0;
      #1;
      chk("async_abort_valid", bit_valid, 0);
      chk("async_abort_busy", busy, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_abort_valid", bit_valid, 0);
      clr();
      send(5'd7);
      wait_idle();
      tick();
      expect_run("cleared_tbl", 0, 32'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
